// File: rtl/ceq_stream_checker.sv
// ceq_stream_checker: streaming 4-state comparator with statistics.
//
// Each accepted transaction extends operands A and B to a common width and
// compares them with ===, !==, == or !=. The 1-bit 4-state result is returned
// in bit 0 of res_val/res_xz over a valid/ready channel through a single
// output register.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   a_val/a_xz        operand A value / unknown planes (AW bits)
//   b_val/b_xz        operand B value / unknown planes (BW bits)
//   mode              0 ===, 1 !==, 2 ==, 3 !=
//   out_valid/out_ready output handshake
//   res_val/res_xz    result planes (OUT_W bits, only bit 0 can be non-zero)
//   clr_stats         synchronous clear of the statistics
//   txn_count         accepted transactions (wraps)
//   fail_count        failing transactions (saturates)
//   first_fail_vld/idx  sticky capture of txn_count at the first fail
//
// Bit encoding {xz,val}: 00=0, 01=1, 10=Z, 11=X.
module ceq_stream_checker #(
  parameter int AW     = 9,
  parameter int BW     = 6,
  parameter int SIGNED = 0,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    a_val,
  input  logic [AW-1:0]    a_xz,
  input  logic [BW-1:0]    b_val,
  input  logic [BW-1:0]    b_xz,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] res_val,
  output logic [OUT_W-1:0] res_xz,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam int W = (AW > BW) ? AW : BW;

  logic [W-1:0] a_val_e, a_xz_e, b_val_e, b_xz_e;

  // Signed extension replicates the whole 4-state MSB code, so an X or Z
  // sign bit propagates into the extension bits.
  generate
    if (W > AW) begin : g_ext_a
      assign a_val_e = {{(W-AW){(SIGNED != 0) ? a_val[AW-1] : 1'b0}}, a_val};
      assign a_xz_e  = {{(W-AW){(SIGNED != 0) ? a_xz[AW-1]  : 1'b0}}, a_xz};
    end else begin : g_noext_a
      assign a_val_e = a_val;
      assign a_xz_e  = a_xz;
    end
    if (W > BW) begin : g_ext_b
      assign b_val_e = {{(W-BW){(SIGNED != 0) ? b_val[BW-1] : 1'b0}}, b_val};
      assign b_xz_e  = {{(W-BW){(SIGNED != 0) ? b_xz[BW-1]  : 1'b0}}, b_xz};
    end else begin : g_noext_b
      assign b_val_e = b_val;
      assign b_xz_e  = b_xz;
    end
  endgenerate

  logic exact_eq, known_ne, any_unk;
  logic cmp_val, cmp_xz, cmp_fail;

  assign exact_eq = (a_val_e == b_val_e) && (a_xz_e == b_xz_e);
  // A known difference dominates any unknown bit for ==/!=.
  assign known_ne = |(~a_xz_e & ~b_xz_e & (a_val_e ^ b_val_e));
  assign any_unk  = |{a_xz_e, b_xz_e};

  always_comb begin
    cmp_val = 1'b0;
    cmp_xz  = 1'b0;
    case (mode)
      2'd0: cmp_val = exact_eq;
      2'd1: cmp_val = ~exact_eq;
      2'd2: begin
        if (known_ne)     begin cmp_val = 1'b0; cmp_xz = 1'b0; end
        else if (any_unk) begin cmp_val = 1'b1; cmp_xz = 1'b1; end
        else              begin cmp_val = 1'b1; cmp_xz = 1'b0; end
      end
      default: begin
        if (known_ne)     begin cmp_val = 1'b1; cmp_xz = 1'b0; end
        else if (any_unk) begin cmp_val = 1'b1; cmp_xz = 1'b1; end
        else              begin cmp_val = 1'b0; cmp_xz = 1'b0; end
      end
    endcase
    cmp_fail = !(cmp_val && !cmp_xz);
  end

  // Output register and statistics
  logic             out_valid_q, out_valid_d;
  logic             r_val_q, r_val_d, r_xz_q, r_xz_d;
  logic [CNT_W-1:0] txn_q, txn_d, fail_q, fail_d, ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    r_val_d     = r_val_q;
    r_xz_d      = r_xz_q;
    if (accept) begin
      out_valid_d = 1'b1;
      r_val_d     = cmp_val;
      r_xz_d      = cmp_xz;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first, then count a same-cycle accept on top of the cleared state.
    txn_d  = clr_stats ? '0 : txn_q;
    fail_d = clr_stats ? '0 : fail_q;
    ffv_d  = clr_stats ? 1'b0 : ffv_q;
    ffi_d  = clr_stats ? '0 : ffi_q;
    if (accept) begin
      if (cmp_fail) begin
        if (fail_d != {CNT_W{1'b1}}) fail_d = fail_d + CNT_W'(1);
        if (!ffv_d) begin
          ffv_d = 1'b1;
          ffi_d = txn_d;
        end
      end
      txn_d = txn_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      r_val_q     <= 1'b0;
      r_xz_q      <= 1'b0;
      txn_q       <= '0;
      fail_q      <= '0;
      ffv_q       <= 1'b0;
      ffi_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_val_q     <= r_val_d;
      r_xz_q      <= r_xz_d;
      txn_q       <= txn_d;
      fail_q      <= fail_d;
      ffv_q       <= ffv_d;
      ffi_q       <= ffi_d;
    end
  end

  always_comb begin
    res_val    = '0;
    res_xz     = '0;
    res_val[0] = r_val_q;
    res_xz[0]  = r_xz_q;
  end

  assign out_valid      = out_valid_q;
  assign txn_count      = txn_q;
  assign fail_count     = fail_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;

endmodule
